// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constant helpers for the UART transmitter
// (and the future receiver).
package uart_pkg;

  // Transmitter FSM states; ST_PARITY is only visited when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Minimum index width able to count 0..value-1 (never less than 1 bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << k) < value) w = k + 1;
    end
    return w;
  endfunction

  // Clocks occupied by one complete frame on the line.
  function automatic int frame_clks(input int data_w, input int p,
                                    input int stop_bits, input int clks_per_bit);
    return (1 + data_w + p + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter. Counts 0..CLKS_PER_BIT-1, wraps by itself
// at the end of each bit and can be held at zero with i_clr.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bit_end
);

  logic [CNT_W-1:0] r_count;

  assign o_count   = r_count;
  assign o_bit_end = (r_count == CNT_W'(CLKS_PER_BIT - 1));

  // Free-running bit counter, restarted at every bit boundary or while cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr || o_bit_end) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: parametrised UART transmitter with a one-word holding register
// so back-to-back frames leave no idle gap on the line.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even/odd selected per word by parity_odd).
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_odd,
  output logic              ready,
  output logic              serial_out,
  output logic              parallel_in_active,
  output logic              done
);

  localparam int BIT_W = clog2(DATA_W);
  localparam int CNT_W = clog2(CLKS_PER_BIT);

  uart_state_e       r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit_idx;
  logic              r_stop_idx;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic              r_serial;
  logic              r_active;
  logic              r_done;

`ifdef UART_TX_PARITY_EN
  logic              r_hold_par_odd;
  logic              r_par_bit;
`else
  logic              w_unused;
  assign w_unused = parity_odd;
`endif

  logic [CNT_W-1:0]  w_count;
  logic              w_bit_end;
  logic              w_baud_clr;
  logic              w_last_stop;
  logic              w_drain;
  logic              w_accept;
  logic              w_done_next;
  logic              w_head;
  logic [DATA_W-1:0] w_shift_next;

  assign ready              = r_ready;
  assign serial_out         = r_serial;
  assign parallel_in_active = r_active;
  assign done               = r_done;

  // The line idles in IDLE, so the counter sits at zero and the start bit
  // always gets a full period.
  assign w_baud_clr = (r_state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_baud_clr),
    .o_count  (w_count),
    .o_bit_end(w_bit_end)
  );

  assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));

  // Held word moves to the shifter from IDLE, or straight from the end of the
  // final stop bit so the next start bit follows with no gap.
  assign w_drain = r_hold_full &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_STOP) && w_bit_end && w_last_stop));

  assign w_accept = load && r_ready;

  // done is registered, so it is armed one clock before the final stop cycle.
  assign w_done_next = (r_state == ST_STOP) && w_last_stop &&
                       (w_count == CNT_W'(CLKS_PER_BIT - 2));

  // Next bit to put on the line and the shifter after it has been consumed.
  assign w_head       = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_W-1];
  assign w_shift_next = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);

  // Holding register: capture on accepted load, release when drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_hold_par_odd <= 1'b0;
`endif
    end else if (w_accept) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
      r_ready     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_hold_par_odd <= parity_odd;
`endif
    end else if (w_drain) begin
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
    end
  end

  // Frame sequencer with registered line, activity and done outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_done <= w_done_next;
      case (r_state)
        ST_IDLE: begin
          if (w_drain) begin
            r_state  <= ST_START;
            r_shift  <= r_hold;
            r_serial <= 1'b0;
            r_active <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_bit <= (^r_hold) ^ r_hold_par_odd;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
            r_serial  <= w_head;
            r_shift   <= w_shift_next;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state  <= ST_PARITY;
              r_serial <= r_par_bit;
`else
              r_state    <= ST_STOP;
              r_serial   <= 1'b1;
              r_stop_idx <= 1'b0;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_serial  <= w_head;
              r_shift   <= w_shift_next;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state    <= ST_STOP;
            r_serial   <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_last_stop) begin
              if (r_hold_full) begin
                r_state  <= ST_START;
                r_shift  <= r_hold;
                r_serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_par_bit <= (^r_hold) ^ r_hold_par_odd;
`endif
              end else begin
                r_state  <= ST_IDLE;
                r_serial <= 1'b1;
                r_active <= 1'b0;
              end
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_serial <= 1'b1;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb_uart_tx_gen: two transmitter configurations checked every cycle against a
// frame-level reference model, plus literal frame patterns from the datasheet.
module tb_uart_tx_gen;

  localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL0 = (1 + 8 + P + 1) * CLKS;  // 8N1 frame
  localparam int FL1 = (1 + 5 + P + 2) * CLKS;  // 5-bit, 2 stop frame

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] load = '0;
  logic [1:0] par_odd = '0;
  logic [7:0] data0 = '0;
  logic [4:0] data1 = '0;
  logic [1:0] ready, sout, active, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_gen #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .STOP_BITS(1), .LSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .load(load[0]), .tx_data(data0), .parity_odd(par_odd[0]),
    .ready(ready[0]), .serial_out(sout[0]), .parallel_in_active(active[0]), .done(done[0])
  );

  uart_tx_gen #(.DATA_W(5), .CLKS_PER_BIT(CLKS), .STOP_BITS(2), .LSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .load(load[1]), .tx_data(data1), .parity_odd(par_odd[1]),
    .ready(ready[1]), .serial_out(sout[1]), .parallel_in_active(active[1]), .done(done[1])
  );

  // ---------------- reference model ----------------
  int cfg_dw    [2] = '{8, 5};
  int cfg_lsb   [2] = '{1, 0};
  int cfg_stops [2] = '{1, 2};

  bit m_line   [2][$];   // remaining line levels of the frame in flight, one per clk
  bit m_hold_v [2];
  int m_hold_w [2];
  bit m_hold_p [2];

  function automatic void push_frame(int i, int w, bit po);
    bit lvl[$];
    bit par;
    bit bt;
    int idx;
    par = po;
    lvl.push_back(1'b0);
    for (int b = 0; b < cfg_dw[i]; b++) begin
      idx = (cfg_lsb[i] != 0) ? b : cfg_dw[i] - 1 - b;
      bt  = ((w >> idx) & 1) != 0;
      par = par ^ bt;
      lvl.push_back(bt);
    end
    if (P == 1) lvl.push_back(par);
    for (int s = 0; s < cfg_stops[i]; s++) lvl.push_back(1'b1);
    foreach (lvl[k]) begin
      for (int c = 0; c < CLKS; c++) m_line[i].push_back(lvl[k]);
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    bit hv;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_line[i].delete();
        m_hold_v[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        hv = m_hold_v[i];
        if (m_line[i].size() > 0) void'(m_line[i].pop_front());
        if (m_line[i].size() == 0 && hv) begin
          push_frame(i, m_hold_w[i], m_hold_p[i]);
          m_hold_v[i] = 1'b0;
        end
        if (load[i] && !hv) begin
          m_hold_w[i] = (i == 0) ? int'(data0) : int'(data1);
          m_hold_p[i] = par_odd[i];
          m_hold_v[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  function automatic void check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check1($sformatf("serial_out[%0d]", i), sout[i],
             (m_line[i].size() > 0) ? m_line[i][0] : 1'b1);
      check1($sformatf("ready[%0d]", i), ready[i], !m_hold_v[i]);
      check1($sformatf("active[%0d]", i), active[i], m_line[i].size() > 0);
      check1($sformatf("done[%0d]", i), done[i], m_line[i].size() == 1);
    end
  end

  // ---------------- stimulus ----------------
  // One-cycle load pulse; returns at the negedge after the accepting edge.
  task automatic send(int i, int w, bit po);
    @(negedge clk);
    load[i]    = 1'b1;
    par_odd[i] = po;
    if (i == 0) data0 = 8'(w);
    else        data1 = 5'(w);
    $display("load dut%0d data=0x%0h parity_odd=%0b", i, w, po);
    @(negedge clk);
    load[i] = 1'b0;
  endtask

  task automatic test_single();
    logic lv [0:63];
    int   dpos, dcnt;
    bit   exp_seq[$];
`ifdef UART_TX_PARITY_EN
    exp_seq = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1};
`else
    exp_seq = '{0, 0, 1, 0, 1, 1, 1, 0, 1, 1};
`endif
    send(0, 'hBA, 1'b0);
    dpos = 0; dcnt = 0;
    for (int c = 1; c <= FL0 + 4; c++) begin
      @(negedge clk);
      lv[c] = sout[0];
      if (done[0]) begin dcnt++; dpos = c; end
      if (c == FL0 + 1) check1("single active after frame", active[0], 1'b0);
    end
    foreach (exp_seq[b]) begin
      check1($sformatf("single bit%0d first clk", b), lv[b*CLKS+1], exp_seq[b]);
      check1($sformatf("single bit%0d last clk", b), lv[b*CLKS+CLKS], exp_seq[b]);
    end
    check_int("single done count", dcnt, 1);
    check_int("single done cycle", dpos, FL0);
    check1("single idle line", lv[FL0+2], 1'b1);
    $display("frame 0xBA done at clk %0d", dpos);
  endtask

  task automatic test_b2b();
    logic lv [0:127];
    logic ac [0:127];
    logic rd [0:127];
    int   dcnt, dlast;
    send(0, 'h55, 1'b0);
    dcnt = 0; dlast = 0;
    for (int c = 1; c <= 2 * FL0 + 8; c++) begin
      @(negedge clk);
      lv[c] = sout[0]; ac[c] = active[0]; rd[c] = ready[0];
      if (done[0]) begin dcnt++; dlast = c; end
      if (c == 12) begin load[0] = 1'b1; data0 = 8'hA3; end
      if (c == 13) load[0] = 1'b0;
      if (c == 16) begin load[0] = 1'b1; data0 = 8'h11; end
      if (c == 17) load[0] = 1'b0;
    end
    check1("b2b active last stop", ac[FL0], 1'b1);
    check1("b2b active second start", ac[FL0+1], 1'b1);
    check1("b2b second start bit", lv[FL0+1], 1'b0);
    check1("b2b ready while held", rd[FL0], 1'b0);
    check1("b2b ready at second start", rd[FL0+1], 1'b1);
    check_int("b2b done count", dcnt, 2);
    check_int("b2b second done cycle", dlast, 2 * FL0);
    check1("b2b idle after second", ac[2*FL0+1], 1'b0);
    $display("back-to-back 0x55,0xA3 done pulses=%0d", dcnt);
  endtask

  task automatic test_reset_mid();
    int dcnt;
    send(0, 'hC6, 1'b0);
    for (int c = 1; c <= 18; c++) @(negedge clk);  // inside data bit 3
    #1 rst = 1'b0;
    #1;
    check1("rst serial_out", sout[0], 1'b1);
    check1("rst ready", ready[0], 1'b1);
    check1("rst active", active[0], 1'b0);
    check1("rst done", done[0], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dcnt = 0;
    for (int c = 0; c < FL0 + 8; c++) begin
      @(negedge clk);
      if (done[0]) dcnt++;
    end
    check_int("rst no done", dcnt, 0);
    $display("reset mid-frame handled");
    send(0, 'h3C, 1'b1);
    @(negedge clk);
    check1("post-rst start bit", sout[0], 1'b0);
    repeat (FL0 + 4) @(negedge clk);
  endtask

  task automatic test_narrow();
    logic lv [0:63];
    int   dpos;
    bit   exp_seq[$];
`ifdef UART_TX_PARITY_EN
    exp_seq = '{0, 1, 0, 0, 1, 1, 1, 1, 1};
`else
    exp_seq = '{0, 1, 0, 0, 1, 1, 1, 1};
`endif
    send(1, 'b10011, 1'b0);
    dpos = 0;
    for (int c = 1; c <= FL1 + 4; c++) begin
      @(negedge clk);
      lv[c] = sout[1];
      if (done[1]) dpos = c;
    end
    foreach (exp_seq[b]) begin
      check1($sformatf("narrow bit%0d", b), lv[b*CLKS+2], exp_seq[b]);
    end
    check_int("narrow done cycle", dpos, FL1);
    $display("frame 5'b10011 done at clk %0d", dpos);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check1("reset serial_out", sout[0], 1'b1);
    check1("reset ready", ready[0], 1'b1);
    check1("reset active", active[0], 1'b0);
    check1("reset done", done[0], 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    test_single();
    test_b2b();
    test_reset_mid();
    test_narrow();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        load[i]    = ($urandom_range(0, 3) == 0);
        par_odd[i] = $urandom_range(0, 1) != 0;
      end
      data0 = 8'($urandom);
      data1 = 5'($urandom);
    end
    @(negedge clk);
    load = '0;
    repeat (3 * FL0) @(negedge clk);
    check1("final idle dut0", active[0], 1'b0);
    check1("final idle dut1", active[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
